// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit 7-segment driver: shadow-latched hex word, one digit per scan slot,
// with leading-zero blanking, per-digit blink, decimal points and selectable polarities.
module seg7_scan_mux #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter bit          DIG_ACT_LOW  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      com,
   input  logic                      enb,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   dat,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic                      blank_lz,
   output logic [6:0]                seg_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     dig_sel
);

   localparam int unsigned PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0]             presc_q, presc_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [FW-1:0]             frame_q, frame_d;
   logic                      phase_q, phase_d;
   logic [4*NUM_DIGITS-1:0]   dat_q, dat_d;
   logic [NUM_DIGITS-1:0]     dp_q, dp_d;
   logic [NUM_DIGITS-1:0]     blink_q, blink_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dpo_q, dpo_d;
   logic [NUM_DIGITS-1:0]     dig_q, dig_d;

   logic                      tick;
   logic [3:0]                nib;
   logic                      dp_sel, blink_sel, lz_hit, zero_above, hard_blank, dp_lit;
   logic [6:0]                segs_low;
   logic [NUM_DIGITS-1:0]     onehot;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      frame_d = frame_q;
      phase_d = phase_q;
      if (tick) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
         if (idx_q == IDX_MAX) begin
            frame_d = (frame_q == FRAME_MAX) ? '0 : frame_q + 1'b1;
            if (frame_q == FRAME_MAX) phase_d = ~phase_q;
         end
      end

      dat_d   = load ? dat        : dat_q;
      dp_d    = load ? dp_in      : dp_q;
      blink_d = load ? blink_mask : blink_q;

      // idx_q is the digit shown from this tick on; the scan from the top tracks
      // whether every nibble at and above it is zero.
      nib        = 4'h0;
      dp_sel     = 1'b0;
      blink_sel  = 1'b0;
      lz_hit     = 1'b0;
      zero_above = 1'b1;
      onehot     = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         zero_above = zero_above & (dat_q[4*i +: 4] == 4'h0);
         if (idx_q == IW'(i)) begin
            nib       = dat_q[4*i +: 4];
            dp_sel    = dp_q[i];
            blink_sel = blink_q[i];
            lz_hit    = zero_above && (i != 0);
            onehot[i] = enb;
         end
      end

      hard_blank = !enb || (blink_sel && phase_q);
      segs_low   = (hard_blank || (blank_lz && lz_hit)) ? 7'h7F : hex_seg(nib);
      dp_lit     = dp_sel && !hard_blank;

      seg_d = seg_q;
      dpo_d = dpo_q;
      dig_d = dig_q;
      if (tick) begin
         seg_d = com ? segs_low : ~segs_low;
         dpo_d = com ? ~dp_lit : dp_lit;
         dig_d = DIG_ACT_LOW ? ~onehot : onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         phase_q <= 1'b0;
         dat_q   <= '0;
         dp_q    <= '0;
         blink_q <= '0;
         seg_q   <= 7'h7F;
         dpo_q   <= 1'b1;
         dig_q   <= {NUM_DIGITS{DIG_ACT_LOW}};
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         phase_q <= phase_d;
         dat_q   <= dat_d;
         dp_q    <= dp_d;
         blink_q <= blink_d;
         seg_q   <= seg_d;
         dpo_q   <= dpo_d;
         dig_q   <= dig_d;
      end
   end

   assign seg_out = seg_q;
   assign dp_out  = dpo_q;
   assign dig_sel = dig_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux; expected outputs come from slot/frame arithmetic
// on the number of clock edges since the last reset.
module tb_seg7_scan_mux;

   localparam int unsigned ND = 4;
   localparam int unsigned SD = 4;
   localparam int unsigned BF = 2;

   logic          clk = 1'b0;
   logic          rst_n, com, enb, load, blank_lz;
   logic [15:0]   dat;
   logic [3:0]    dp_in, blink_mask;
   logic [6:0]    seg_out;
   logic          dp_out;
   logic [3:0]    dig_sel;

   seg7_scan_mux #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .BLINK_FRAMES (BF),
      .DIG_ACT_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .com        (com),
      .enb        (enb),
      .load       (load),
      .dat        (dat),
      .dp_in      (dp_in),
      .blink_mask (blink_mask),
      .blank_lz   (blank_lz),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .dig_sel    (dig_sel)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int unsigned edges;
   logic [15:0] sh_dat;
   logic [3:0]  sh_dp, sh_blink;
   logic [6:0]  exp_seg;
   logic        exp_dp;
   logic [3:0]  exp_dig;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Applied once per rising edge with the inputs that edge sees.
   task automatic model_step();
      int unsigned k, d, ph;
      logic [6:0]  s;
      logic        hard, lz, lit;
      if (!rst_n) begin
         edges    = 0;
         sh_dat   = '0;
         sh_dp    = '0;
         sh_blink = '0;
         exp_seg  = 7'h7F;
         exp_dp   = 1'b1;
         exp_dig  = 4'hF;
         return;
      end
      if (edges % SD == SD - 1) begin
         k    = edges / SD;
         d    = k % ND;
         ph   = (k / ND / BF) % 2;
         hard = !enb || (sh_blink[d] && ph == 1);
         lz   = blank_lz && d != 0 && (sh_dat >> (4 * d)) == 16'h0;
         s    = (hard || lz) ? 7'h7F : hex_tab[(sh_dat >> (4 * d)) & 16'hF];
         lit  = sh_dp[d] && !hard;
         exp_seg = com ? s : ~s;
         exp_dp  = com ? !lit : lit;
         exp_dig = enb ? ~(4'b0001 << d) : 4'hF;
      end
      if (load) begin
         sh_dat   = dat;
         sh_dp    = dp_in;
         sh_blink = blink_mask;
      end
      edges++;
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      for (int i = 0; i < 4; i++)
         w[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return w;
   endfunction

   initial begin
      rst_n      = 1'b0;
      com        = 1'b1;
      enb        = 1'b1;
      load       = 1'b0;
      blank_lz   = 1'b0;
      dat        = 16'h12AF;
      dp_in      = 4'h0;
      blink_mask = 4'h0;
      @(posedge clk);
      model_step();
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(negedge clk);
         check_eq("seg_out", 32'(seg_out), 32'(exp_seg));
         check_eq("dp_out", 32'(dp_out), 32'(exp_dp));
         check_eq("dig_sel", 32'(dig_sel), 32'(exp_dig));

         rst_n = (cyc < 2 || $urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         load  = (cyc == 1) || ($urandom_range(0, 7) == 0);
         if (load && cyc > 1) begin
            dat        = rand_word();
            dp_in      = 4'($urandom_range(0, 15));
            blink_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         end
         if ($urandom_range(0, 15) == 0) com      = ~com;
         if ($urandom_range(0, 23) == 0) enb      = ~enb;
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;

         @(posedge clk);
         model_step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
